// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, button indices and output decode
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        STOPPED = 2'd3
    } state_e;

    localparam int BTN_STARTSTOP = 0;
    localparam int BTN_CLEAR     = 1;
    localparam int BTN_LAP       = 2;

    typedef struct packed {
        logic clear;
        logic enable;
        logic hold;
    } ctl_t;

    function automatic ctl_t state_ctl(input state_e s);
        ctl_t c;
        c = '{clear: 1'b0, enable: 1'b0, hold: 1'b0};
        case (s)
            IDLE:    c.clear  = 1'b1;
            RUNNING: c.enable = 1'b1;
            LAP: begin
                c.enable = 1'b1;
                c.hold   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stopwatch_control_button_debouncer.sv
// rtl/stopwatch_control_button_debouncer.sv - synchronise and debounce one active-low button
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Press fires one cycle after the stable level has fallen; releases are silent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - button conditioning and run/stop/lap/clear state machine
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button0,
    input  logic       button1,
    input  logic       button2,
    output logic       count_enable,
    output logic       count_clear,
    output logic       display_hold,
    output logic [2:0] press
);

    logic [2:0] raw_w;
    logic [2:0] level_w;
    logic [2:0] press_w;

    assign raw_w = {button2, button1, button0};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock(clock),
            .reset(reset),
            .raw  (raw_w[i]),
            .level(level_w[i]),
            .press(press_w[i])
        );
    end

    state_e state_q, state_d;
    ctl_t   ctl_q;

    // Lower-priority events are dropped when a higher-priority legal one fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_w[BTN_STARTSTOP])  state_d = RUNNING;
                else if (press_w[BTN_CLEAR]) state_d = IDLE;
            end
            RUNNING: begin
                if (press_w[BTN_STARTSTOP])  state_d = STOPPED;
                else if (press_w[BTN_LAP])   state_d = LAP;
            end
            LAP: begin
                if (press_w[BTN_STARTSTOP])  state_d = STOPPED;
                else if (press_w[BTN_LAP])   state_d = RUNNING;
            end
            STOPPED: begin
                if (press_w[BTN_STARTSTOP])  state_d = RUNNING;
                else if (press_w[BTN_CLEAR]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ctl_q   <= state_ctl(IDLE);
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d);
        end
    end

    assign count_clear  = ctl_q.clear;
    assign count_enable = ctl_q.enable;
    assign display_hold = ctl_q.hold;
    assign press        = press_w;

endmodule

// File: tb/tb_stopwatch_control.sv
// tb/tb_stopwatch_control.sv - directed self-checking bench for stopwatch_control
module tb_stopwatch_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic       count_enable, count_clear, display_hold;
    logic [2:0] press;
    int         checks = 0;
    int         errors = 0;

    stopwatch_control #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .button0     (btn[0]),
        .button1     (btn[1]),
        .button2     (btn[2]),
        .count_enable(count_enable),
        .count_clear (count_clear),
        .display_hold(display_hold),
        .press       (press)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] C_IDLE = 3'b100;
    localparam logic [2:0] C_RUN  = 3'b010;
    localparam logic [2:0] C_LAP  = 3'b011;
    localparam logic [2:0] C_STOP = 3'b000;

    function automatic logic [2:0] ctl();
        return {count_clear, count_enable, display_hold};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold one button 12 cycles from a fall just after an edge, then release and settle.
    task automatic press_btn(input int idx, input logic [2:0] exp_ctl, input string tag);
        logic [2:0] pre;
        logic [2:0] onehot;
        onehot = 3'b001 << idx;
        pre = ctl();
        btn[idx] = 1'b0;
        repeat (6) tick();
        chk({tag, " press early"}, {5'd0, press}, 8'd0);
        tick();
        chk({tag, " press at 7"}, {5'd0, press}, {5'd0, onehot});
        chk({tag, " ctl before 8"}, {5'd0, ctl()}, {5'd0, pre});
        tick();
        chk({tag, " press gone"}, {5'd0, press}, 8'd0);
        chk({tag, " ctl at 8"}, {5'd0, ctl()}, {5'd0, exp_ctl});
        repeat (4) tick();
        btn[idx] = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        logic [2:0] seen;
        logic       clr_seen;
        reset = 1'b0;
        btn   = 3'b111;
        tick();
        tick();
        chk("reset ctl", {5'd0, ctl()}, {5'd0, C_IDLE});
        chk("reset press", {5'd0, press}, 8'd0);
        reset = 1'b1;
        repeat (3) tick();

        press_btn(0, C_RUN, "clean start");
        press_btn(2, C_LAP, "lap on");
        press_btn(2, C_RUN, "lap off");
        press_btn(0, C_STOP, "stop");
        press_btn(1, C_IDLE, "clear");

        seen = 3'b000;
        for (int i = 0; i < 20; i++) begin
            btn[0] = (i % 4) >= 2;
            tick();
            seen |= press;
        end
        btn[0] = 1'b1;
        repeat (10) begin
            tick();
            seen |= press;
        end
        chk("bounce no press", {5'd0, seen}, 8'd0);
        chk("bounce idle", {5'd0, ctl()}, {5'd0, C_IDLE});

        press_btn(0, C_RUN, "to run");
        press_btn(0, C_STOP, "to stop");
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        seen = 3'b000;
        clr_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= press;
            clr_seen |= count_clear;
        end
        chk("simul press both", {5'd0, seen}, 8'd3);
        chk("simul no clear", {7'd0, clr_seen}, 8'd0);
        chk("simul running", {5'd0, ctl()}, {5'd0, C_RUN});
        btn = 3'b111;
        repeat (10) tick();
        press_btn(1, C_RUN, "clear ignored");

        btn[0] = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("mid reset ctl", {5'd0, ctl()}, {5'd0, C_IDLE});
        chk("mid reset press", {5'd0, press}, 8'd0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("post reset early", {5'd0, press}, 8'd0);
        tick();
        chk("post reset press", {5'd0, press}, 8'd1);
        chk("post reset idle", {5'd0, ctl()}, {5'd0, C_IDLE});
        tick();
        chk("post reset run", {5'd0, ctl()}, {5'd0, C_RUN});
        repeat (4) tick();
        btn[0] = 1'b1;
        repeat (10) tick();

        press_btn(2, C_LAP, "lap before reset");
        reset = 1'b0;
        #1;
        chk("lap reset ctl", {5'd0, ctl()}, {5'd0, C_IDLE});
        repeat (3) tick();
        reset = 1'b1;
        seen = 3'b000;
        clr_seen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= press;
            clr_seen &= (ctl() == C_IDLE);
        end
        chk("idle hold press", {5'd0, seen}, 8'd0);
        chk("idle hold ctl", {7'd0, clr_seen}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
